seq_multiplier: RTL
===================

# seq_multiplier

Parametrised sequential shift-add unsigned multiplier: the next generation of the multiplier register datapath, now with its own adder, iteration counter and control FSM behind a start/done handshake. Accepts two WIDTH-bit operands, performs one add-and-shift per clock over a (2·WIDTH+1)-bit working register, and presents a 2·WIDTH-bit product. Sits between the operand source and the result consumer as a self-contained multiply unit.

## Interface

- WIDTH, 8, operand width in bits; legal range 2..32
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only while ready=1
- multiplicand  input  WIDTH  operand A; captured on accepted start
- multiplier  input  WIDTH  operand B; captured on accepted start
- ready  output  1  high in IDLE only
- busy  output  1  high in RUN only
- done  output  1  one-cycle pulse, high in DONE only
- product  output  2·WIDTH  low 2·WIDTH bits of working register

## Operation

- Working register R[2W:0] = {carry, acc[W-1:0], mplr[W-1:0]}; mcand register M[W-1:0]; counter cnt, width clog2(W+1).
- Reset (async, any state, including mid-operation): state=IDLE, R=0, M=0, cnt=0; outputs ready=1, busy=0, done=0, product=0.
- IDLE: start=1 at edge -> M<=multiplicand, R<={1'b0, W'b0, multiplier}, cnt<=0, state<=RUN. start=0 -> hold everything.
- RUN, per edge (normal iteration): if R[0]=1, {carry,acc}<=acc+M (W+1-bit sum, carry kept); otherwise unchanged. The whole (2W+1)-bit result is then shifted right by one, zero into MSB; cnt<=cnt+1. The add and the shift land in the same edge. When cnt reaches W, state<=DONE.
- DONE: done=1 for exactly one cycle; next edge -> IDLE. R holds.
- product = R[2W-1:0] at all times; valid and stable from DONE until the next accepted start. During RUN it shows intermediate values and must not be consumed.
- start while busy or done: ignored, no effect on operands or result.
- Operand inputs are don't-care except on the accepting edge.
- Arithmetic is unsigned; R[2W] is always 0 after the final shift; no overflow possible.

## Timing

- Accepting edge E0. Iterations at E1..EW. done high in the cycle between EW and EW+1. ready high again after EW+1.
- Fixed latency without the configuration feature: done sampled high at edge W+1 after E0; a new start can be accepted at edge W+2 at the earliest.
- Back-to-back: start held high continuously yields one operation every W+2 cycles.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.

## Configuration

- SEQ_MULTIPLIER_EARLY_EXIT_EN defined: at each RUN edge, check before the normal iteration whether the unconsumed multiplier bits R[W-1-cnt:0] are all zero. If so, R<=R>>(W-cnt) in a single edge, state<=DONE, and cnt is not incremented further. The product is identical to the full run. Latency becomes variable: done sampled high at edge (k+2), where k is the index of the highest set multiplier bit plus 1 (k=0 for a zero multiplier), capped at W+1.
- Not defined: fixed W iterations, and no variable shifter is synthesised.

## Test plan

- W=8, reset then 152×73 -> done pulse exactly 9 edges after accepting edge (without macro), product=0x2B58, ready returns after next edge.
- 255×255 (carry path) -> product=0xFE01. 0×0 -> 0. 1×255 -> 0x00FF. 128×2 -> 0x0100.
- start pulsed during RUN with different operands -> ignored; first result 152×73=0x2B58 unchanged, done once.
- Assert reset during the 4th iteration of 200×201 -> immediately ready=1, busy=0, done=0, product=0. Then 200×201 restarted -> 0x9D08.
- With SEQ_MULTIPLIER_EARLY_EXIT_EN: 200×0 -> done sampled at edge 2, product 0. 200×1 -> edge 3, product 0x00C8. 200×128 -> edge 9, product 0x6400.
- Random 500 operand pairs, W=8 and W=16, start held high back-to-back -> each product equals A·B and each done is a single-cycle pulse.

Source files
------------

// File: rtl/seq_multiplier.sv
// Sequential shift-add unsigned multiplier: one add-and-shift per clock behind a start/done handshake.
// Optional early termination on exhausted multiplier bits: define SEQ_MULTIPLIER_EARLY_EXIT_EN.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [2*WIDTH:0]   r_reg, r_next;
  logic [WIDTH-1:0]   m_reg, m_next;
  logic [CW-1:0]      cnt_reg, cnt_next;

  // {carry, acc, mplr}: the add lands in the upper W+1 bits before the common shift
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   r_iter;

  assign sum    = {1'b0, r_reg[2*WIDTH-1:WIDTH]} + {1'b0, m_reg};
  assign r_iter = r_reg[0] ? {sum, r_reg[WIDTH-1:0]} : r_reg;

`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
  logic [WIDTH-1:0]   rem_mask;
  logic               rem_zero;
  logic [CW-1:0]      exit_shamt;

  // Low W-cnt bits of R are the multiplier bits still to be consumed
  assign rem_mask   = {WIDTH{1'b1}} >> cnt_reg;
  assign rem_zero   = (r_reg[WIDTH-1:0] & rem_mask) == '0;
  assign exit_shamt = CW'(WIDTH) - cnt_reg;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      r_reg     <= '0;
      m_reg     <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      r_reg     <= r_next;
      m_reg     <= m_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    r_next     = r_reg;
    m_next     = m_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          m_next     = multiplicand;
          r_next     = {1'b0, {WIDTH{1'b0}}, multiplier};
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        r_next   = r_iter >> 1;
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == LAST_CNT) begin
          state_next = DONE;
        end
`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
        if (rem_zero) begin
          r_next     = r_reg >> exit_shamt;
          cnt_next   = cnt_reg;
          state_next = DONE;
        end
`endif
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign ready   = (state_reg == IDLE);
  assign busy    = (state_reg == RUN);
  assign done    = (state_reg == DONE);
  assign product = r_reg[2*WIDTH-1:0];

endmodule
